// File: rtl/polar_enc_ctrl.sv
// polar_enc_ctrl: frame scheduler for the 256-bit polar encoder path.
// Collects a 128-bit info block, hands it to the frozen-bit mixer and runs 8 butterfly stages (one per cycle).
// Then streams the codeword out. Optional macro POLAR_ENC_BITREV_EN emits the codeword in bit-reversed index order.
module polar_enc_ctrl #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              mix_vld_i,
  output logic [127:0]      mix_din,
  input  logic              mix_vld_o,
  input  logic [255:0]      mix_dout,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int IN_BEATS  = 128 / IN_W;
  localparam int OUT_BEATS = 256 / OUT_W;
  localparam int KW = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
  localparam int JW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(IN_BEATS - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_MIX     = 3'd2,
    S_WAIT    = 3'd3,
    S_XFORM   = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [127:0]     info_q;
  logic [KW-1:0]    k_q;
  logic [255:0]     cw_q;
  logic [2:0]       s_q;
  logic [JW-1:0]    j_q;
  logic [7:0][255:0] stg;
  logic [255:0]     cw_sel;

  // One butterfly stage per s: lower half of each 2^(s+1) group absorbs its upper partner.
  for (genvar gs = 0; gs < 8; gs++) begin : g_stage
    for (genvar gi = 0; gi < 256; gi++) begin : g_bit
      if (((gi >> gs) % 2) == 0) begin : g_xor
        assign stg[gs][gi] = cw_q[gi] ^ cw_q[gi + (2 ** gs)];
      end else begin : g_pass
        assign stg[gs][gi] = cw_q[gi];
      end
    end
  end

`ifdef POLAR_ENC_BITREV_EN
  // Output index i reads codeword bit bitrev8(i); pure wiring, no extra latency.
  for (genvar gi = 0; gi < 256; gi++) begin : g_rev
    localparam int RV = ((gi & 1) << 7) | ((gi & 2) << 5) | ((gi & 4) << 3) | ((gi & 8) << 1) |
                        ((gi & 16) >> 1) | ((gi & 32) >> 3) | ((gi & 64) >> 5) | ((gi & 128) >> 7);
    assign cw_sel[gi] = cw_q[RV];
  end
`else
  assign cw_sel = cw_q;
`endif

  // The assembled block is held until the next frame's first beat overwrites it.
  assign mix_din  = info_q;
  assign out_data = out_valid ? cw_sel[j_q*OUT_W +: OUT_W] : '0;
  assign out_last = out_valid && (j_q == J_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mix_vld_i = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid && (k_q == K_LAST)) state_nxt = S_MIX;
      end
      S_MIX: begin
        mix_vld_i = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mix_vld_o) state_nxt = S_XFORM;
      end
      S_XFORM: begin
        if (s_q == 3'd7) state_nxt = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready && (j_q == J_LAST)) state_nxt = S_COLLECT;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: input assembly, codeword capture, in-place transform, output beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      info_q <= '0;
      k_q    <= '0;
      cw_q   <= '0;
      s_q    <= '0;
      j_q    <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_valid) begin
            info_q[k_q*IN_W +: IN_W] <= in_data;
            k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (mix_vld_o) begin
            cw_q <= mix_dout;
            s_q  <= '0;
          end
        end
        S_XFORM: begin
          cw_q <= stg[s_q];
          s_q  <= s_q + 3'd1;
          if (s_q == 3'd7) j_q <= '0;
        end
        S_SEND: begin
          if (out_ready) j_q <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/polar_enc_ctrl.md
Name: polar_enc_ctrl

Overview:
Frame scheduler for the 256-bit polar encoder path. Collects a 128-bit information block from a narrow valid/ready input stream and issues it to the external frozen-bit mixer (one-cycle-latency 128->256 bit placement stage). It captures the mixer output, runs the 8-stage polar butterfly transform iteratively at one stage per cycle, and streams the 256-bit codeword out on a narrow valid/ready port.

Parameters:
IN_W, 32, input beat width; must divide 128; IN_BEATS = 128/IN_W
OUT_W, 32, output beat width; must divide 256; OUT_BEATS = 256/OUT_W

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input beat valid
in_data  input  IN_W  information bits; beat k carries info[k*IN_W +: IN_W]
in_ready  output  1  block accepts an input beat
mix_vld_i  output  1  one-cycle start pulse to mixer
mix_din  output  128  assembled information block to mixer
mix_vld_o  input  1  mixer output valid
mix_dout  input  256  mixed vector u (frozen positions zero)
out_valid  output  1  codeword beat valid
out_data  output  OUT_W  codeword beat; beat j = x[j*OUT_W +: OUT_W]
out_last  output  1  high on final codeword beat
out_ready  input  1  downstream accepts beat
busy  output  1  high in any state other than IDLE/COLLECT

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- All registers reset to 0; state = IDLE. Reset outputs: in_ready=0, mix_vld_i=0, mix_din=0, out_valid=0, out_data=0, out_last=0, busy=0.
- IDLE: unconditional -> COLLECT next cycle.
- COLLECT: in_ready=1. On in_valid&in_ready, write in_data into buf[k*IN_W +: IN_W] and increment k. On beat k=IN_BEATS-1: k<=0, -> MIX.
- MIX: mix_vld_i=1 for exactly this cycle; -> WAIT. mix_din = buf, held stable from MIX until the next frame's first accepted beat.
- WAIT: on mix_vld_o=1, cw <= mix_dout, s <= 0, -> XFORM. mix_vld_o outside WAIT is ignored. No timeout.
- XFORM: 8 cycles, s = 0..7. At each clock edge, for every i in 0..255 with bit s of i = 0: cw[i] <= cw[i] ^ cw[i + 2^s]. After s=7 -> SEND, j <= 0. Result: x[i] = XOR of u[m] over all m whose set bits are a superset of i's set bits.
- SEND: out_valid=1, out_data = cw[j*OUT_W +: OUT_W], out_last = (j == OUT_BEATS-1). out_data/out_last are stable while out_ready=0. On handshake, j++. The handshake on the last beat -> COLLECT; in_ready is asserted the next cycle.
- Latency, with a one-cycle mixer: last input handshake at cycle T; mix_vld_i high at T+1; mix_vld_o at T+2; XFORM T+3..T+10; first out_valid at T+11.
- No overlap: in_ready=0 from MIX until the final output handshake. Input beats offered then are not accepted.
- Reset mid-frame: partial input or codeword is discarded; restart at IDLE with k=j=s=0.

Optional Feature:
POLAR_ENC_BITREV_EN
- Defined: SEND outputs the bit-reversed codeword y[i] = x[bitrev8(i)] (bitrev8 reverses the 8-bit index), selected combinationally from cw. Latency is unchanged.
- Undefined: natural order y = x.

Test Plan:
- Reset then idle: all outputs 0 during reset; in_ready=1 on the second cycle after release; busy=0.
- Bench mixer stub returns mix_dout with only bit 0 set -> codeword has only bit 0 set; out beat 0 = 32'h00000001, beats 1..7 = 0, out_last on beat 7.
- Stub returns only bit 200 set -> codeword bits {0,8,64,72,128,136,192,200} = 1. Beat 0 = 32'h00000101, beat 2 = 32'h00000101, beat 4 = 32'h00000101, beat 6 = 32'h00000101, others 0. With POLAR_ENC_BITREV_EN: bits {0,16,2,18,1,17,3,19} = 1 -> beat 0 = 32'h000F000F.
- Stub returns all-ones -> only x[255] = 1 (beat 7 = 32'h80000000). Checks: mix_din equals the four input words 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F at [31:0]..[127:96]; mix_vld_i is exactly one cycle wide; first out_valid at T+11.
- Random out_ready stalls and in_valid gaps -> out_data/out_last stable under stall; in_ready=0 while busy; back-to-back frames output correctly.
- rst_n asserted during XFORM and again mid-SEND -> outputs clear immediately; the next full frame encodes correctly.
